conv_acc_feeder: RTL and testbench
==================================

Name: conv_acc_feeder

Overview:
- Host-side driver for the convolution accelerator: it is the producer and initiator that talks to the accelerator's start_conv / cfg / ifm / weight / ifm_read / wgt_read / stall / end_op interface.
- Buffers upstream IFM and weight valid/ready streams in two FIFOs and presents each FIFO head to the accelerator.
- Asserts stall whenever the accelerator requests a word that is not yet buffered.
- Sequences one convolution per command through a start / run / done state machine and keeps word and stall counters.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO (power of two).
- ADDR_W, 4, log2(FIFO_DEPTH).
- IFM_W, 64, IFM word width (8 rows x 8 bits).
- WGT_W, 32, weight word width (4 x 8 bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_ci  in  32  input-channel count for the command.
- cmd_co  in  32  output-channel count for the command.
- s_ifm_data  in  IFM_W  upstream IFM word.
- s_ifm_valid  in  1  upstream IFM valid.
- s_ifm_ready  out  1  IFM FIFO not full.
- s_wgt_data  in  WGT_W  upstream weight word.
- s_wgt_valid  in  1  upstream weight valid.
- s_wgt_ready  out  1  weight FIFO not full.
- start_conv  out  1  one-cycle start pulse to the accelerator.
- cfg_ci  out  32  latched ci, to the accelerator.
- cfg_co  out  32  latched co, to the accelerator.
- ifm  out  IFM_W  IFM FIFO head (zero when empty).
- weight  out  WGT_W  weight FIFO head (zero when empty).
- ifm_read  in  1  accelerator samples ifm this cycle.
- wgt_read  in  1  accelerator samples weight this cycle.
- end_op  in  1  accelerator finished.
- stall  out  1  freezes the accelerator.
- busy  out  1  high in START, RUN and DONE.
- done  out  1  one-cycle completion pulse.
- ifm_cnt  out  32  IFM words delivered in the current command.
- wgt_cnt  out  32  weight words delivered in the current command.
- stall_cnt  out  32  stalled cycles in the current command.

Behaviour:
- Reset values (async, rst=1): state=IDLE, both FIFOs empty, all counters 0, cfg_ci=cfg_co=0, start_conv=0, stall=0, done=0, busy=0, cmd_ready=1, s_ifm_ready=1, s_wgt_ready=1.
- FIFOs: synchronous write/read pointers of ADDR_W+1 bits; full when MSBs differ and LSBs are equal.
- FIFO push: on s_*_valid & s_*_ready. s_*_ready = !full, registered-state based; it does not depend on the same-cycle pop.
- ifm/weight outputs: combinational from the FIFO head, so the accelerator samples them in the same cycle it raises *_read. An empty FIFO drives 0.
- FSM states:
  - IDLE: cmd_ready=1. On a command handshake, latch cmd_ci/cmd_co into cfg_ci/cfg_co, clear all three counters, go to START.
  - START: start_conv=1 for exactly this cycle; next state RUN.
  - RUN: stall and pops are active. When end_op=1 is sampled, go to DONE.
  - DONE: done=1 for one cycle; next state IDLE.
- stall is combinational: stall = (state==RUN) & ((ifm_read & ifm_empty) | (wgt_read & wgt_empty)).
- Pops:
  - IFM pop = RUN & ifm_read & !stall.
  - Weight pop = RUN & wgt_read & !stall.
  - When stall is high, neither FIFO pops, even if one of them is non-empty, because the accelerator is frozen and will re-present both reads.
- Counters:
  - ifm_cnt/wgt_cnt increment once per pop.
  - stall_cnt increments every RUN cycle with stall=1.
  - All three wrap modulo 2^32.
  - They hold their values after DONE until the next command is accepted.
- Outside RUN, *_read is ignored: no pop, stall=0.
- Prefetch: upstream data may be pushed in any state, including IDLE before a command. FIFOs are not flushed between commands.
- Push and pop in the same cycle on a non-full, non-empty FIFO: both occur, occupancy unchanged.
- Push into an empty FIFO while ifm_read is high: stall stays 1 in that cycle. The data becomes the head in the next cycle, and stall drops then.
- end_op coincident with stall=1: the transition to DONE still occurs and no pop happens that cycle.
- cmd_valid outside IDLE: held off (cmd_ready=0), command not lost.
- rst asserted mid-RUN: everything returns to reset values immediately; buffered data is discarded.

Test Plan:
- Reset, push IFM words 0x01..0x04 while in IDLE → s_ifm_ready=1 throughout, ifm=0x01, stall=0, ifm_cnt=0.
- Command ci=4, co=8 → start_conv high exactly one cycle after acceptance, cfg_ci=4, cfg_co=8, busy=1, cmd_ready=0.
- RUN with 4 IFM and 4 weight words buffered; accelerator reads 4 of each back-to-back → stall never asserted, ifm_cnt=4, wgt_cnt=4; end_op → done pulse, then IDLE.
- Empty weight FIFO with wgt_read=1 and ifm_read=1 for 3 cycles, weight pushed in cycle 3 → stall=1 for 3 cycles, no IFM pop during them, stall_cnt=3, both pop in cycle 4.
- Fill the IFM FIFO with 16 words → s_ifm_ready=0; one pop → s_ifm_ready=1 in the next cycle; order preserved, word 17 lands after word 16.
- rst pulse mid-RUN with 5 words buffered → FIFOs empty, state IDLE, counters 0, stall=0 asynchronously.

Source files
------------

// File: rtl/conv_acc_feeder.sv
// Host-side feeder for the convolution accelerator: buffers upstream IFM and
// weight streams, presents FIFO heads, stalls on missing words and sequences
// one convolution per command while counting delivered words and stalls.
module conv_acc_feeder #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int IFM_W      = 64,
   parameter int WGT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_ci,
   input  logic [31:0]      cmd_co,
   input  logic [IFM_W-1:0] s_ifm_data,
   input  logic             s_ifm_valid,
   output logic             s_ifm_ready,
   input  logic [WGT_W-1:0] s_wgt_data,
   input  logic             s_wgt_valid,
   output logic             s_wgt_ready,
   output logic             start_conv,
   output logic [31:0]      cfg_ci,
   output logic [31:0]      cfg_co,
   output logic [IFM_W-1:0] ifm,
   output logic [WGT_W-1:0] weight,
   input  logic             ifm_read,
   input  logic             wgt_read,
   input  logic             end_op,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [31:0]      ifm_cnt,
   output logic [31:0]      wgt_cnt,
   output logic [31:0]      stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

   state_t state_q, state_d;

   logic [IFM_W-1:0] ifm_mem_q [FIFO_DEPTH];
   logic [WGT_W-1:0] wgt_mem_q [FIFO_DEPTH];
   logic [ADDR_W:0]  ifm_wp_q, ifm_rp_q, wgt_wp_q, wgt_rp_q;
   logic [31:0]      cfg_ci_q, cfg_ci_d, cfg_co_q, cfg_co_d;
   logic [31:0]      ifm_cnt_q, ifm_cnt_d, wgt_cnt_q, wgt_cnt_d, stall_cnt_q, stall_cnt_d;

   logic ifm_empty, ifm_full, wgt_empty, wgt_full;
   logic ifm_push, wgt_push, ifm_pop, wgt_pop, run;

   assign ifm_empty = (ifm_wp_q == ifm_rp_q);
   assign wgt_empty = (wgt_wp_q == wgt_rp_q);
   assign ifm_full  = (ifm_wp_q[ADDR_W] != ifm_rp_q[ADDR_W]) &&
                      (ifm_wp_q[ADDR_W-1:0] == ifm_rp_q[ADDR_W-1:0]);
   assign wgt_full  = (wgt_wp_q[ADDR_W] != wgt_rp_q[ADDR_W]) &&
                      (wgt_wp_q[ADDR_W-1:0] == wgt_rp_q[ADDR_W-1:0]);

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign s_ifm_ready = !ifm_full;
   assign s_wgt_ready = !wgt_full;
   assign ifm_push    = s_ifm_valid && !ifm_full;
   assign wgt_push    = s_wgt_valid && !wgt_full;

   assign run   = (state_q == S_RUN);
   // A missing word on either side freezes the accelerator; neither side pops
   // since both reads will be re-presented.
   assign stall   = run && ((ifm_read && ifm_empty) || (wgt_read && wgt_empty));
   assign ifm_pop = run && ifm_read && !stall;
   assign wgt_pop = run && wgt_read && !stall;

   assign ifm    = ifm_empty ? '0 : ifm_mem_q[ifm_rp_q[ADDR_W-1:0]];
   assign weight = wgt_empty ? '0 : wgt_mem_q[wgt_rp_q[ADDR_W-1:0]];

   assign cmd_ready  = (state_q == S_IDLE);
   assign start_conv = (state_q == S_START);
   assign done       = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign cfg_ci     = cfg_ci_q;
   assign cfg_co     = cfg_co_q;
   assign ifm_cnt    = ifm_cnt_q;
   assign wgt_cnt    = wgt_cnt_q;
   assign stall_cnt  = stall_cnt_q;

   // FIFO storage; contents are discarded on reset by clearing the pointers.
   always_ff @(posedge clk) begin
      if (ifm_push) ifm_mem_q[ifm_wp_q[ADDR_W-1:0]] <= s_ifm_data;
      if (wgt_push) wgt_mem_q[wgt_wp_q[ADDR_W-1:0]] <= s_wgt_data;
   end

   // FIFO pointers advance on push / pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifm_wp_q <= '0;
         ifm_rp_q <= '0;
         wgt_wp_q <= '0;
         wgt_rp_q <= '0;
      end else begin
         if (ifm_push) ifm_wp_q <= ifm_wp_q + 1'b1;
         if (ifm_pop)  ifm_rp_q <= ifm_rp_q + 1'b1;
         if (wgt_push) wgt_wp_q <= wgt_wp_q + 1'b1;
         if (wgt_pop)  wgt_rp_q <= wgt_rp_q + 1'b1;
      end
   end

   // Next-state: command sequencing, config latch and counters.
   always_comb begin
      state_d     = state_q;
      cfg_ci_d    = cfg_ci_q;
      cfg_co_d    = cfg_co_q;
      ifm_cnt_d   = ifm_cnt_q + {31'd0, ifm_pop};
      wgt_cnt_d   = wgt_cnt_q + {31'd0, wgt_pop};
      stall_cnt_d = stall_cnt_q + {31'd0, stall};
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            cfg_ci_d    = cmd_ci;
            cfg_co_d    = cmd_co;
            ifm_cnt_d   = '0;
            wgt_cnt_d   = '0;
            stall_cnt_d = '0;
            state_d     = S_START;
         end
         S_START: state_d = S_RUN;
         S_RUN:   if (end_op) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, config and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cfg_ci_q    <= '0;
         cfg_co_q    <= '0;
         ifm_cnt_q   <= '0;
         wgt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cfg_ci_q    <= cfg_ci_d;
         cfg_co_q    <= cfg_co_d;
         ifm_cnt_q   <= ifm_cnt_d;
         wgt_cnt_q   <= wgt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_conv_acc_feeder.sv
// Self-checking bench for conv_acc_feeder: a queue-based reference model of
// the feeder is advanced each clock and a negedge monitor compares the DUT.
module tb_conv_acc_feeder;

   logic        clk = 0, rst = 1;
   logic        cmd_valid = 0, cmd_ready;
   logic [31:0] cmd_ci = 0, cmd_co = 0;
   logic [63:0] s_ifm_data = 0;
   logic        s_ifm_valid = 0, s_ifm_ready;
   logic [31:0] s_wgt_data = 0;
   logic        s_wgt_valid = 0, s_wgt_ready;
   logic        start_conv;
   logic [31:0] cfg_ci, cfg_co;
   logic [63:0] ifm;
   logic [31:0] weight;
   logic        ifm_read = 0, wgt_read = 0, end_op = 0;
   logic        stall, busy, done;
   logic [31:0] ifm_cnt, wgt_cnt, stall_cnt;

   conv_acc_feeder dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ci(cmd_ci), .cmd_co(cmd_co),
      .s_ifm_data(s_ifm_data), .s_ifm_valid(s_ifm_valid), .s_ifm_ready(s_ifm_ready),
      .s_wgt_data(s_wgt_data), .s_wgt_valid(s_wgt_valid), .s_wgt_ready(s_wgt_ready),
      .start_conv(start_conv), .cfg_ci(cfg_ci), .cfg_co(cfg_co),
      .ifm(ifm), .weight(weight), .ifm_read(ifm_read), .wgt_read(wgt_read),
      .end_op(end_op), .stall(stall), .busy(busy), .done(done),
      .ifm_cnt(ifm_cnt), .wgt_cnt(wgt_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 start, 2 run, 3 done.
   int          ph;
   logic [63:0] mi[$];
   logic [31:0] mw[$];
   logic [31:0] m_ci, m_co, m_icnt, m_wcnt, m_scnt;

   function automatic bit m_stall();
      return (ph == 2) && ((ifm_read && mi.size() == 0) || (wgt_read && mw.size() == 0));
   endfunction

   bit st, pi, pw, shi, shw;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph = 0; mi.delete(); mw.delete();
         m_ci = 0; m_co = 0; m_icnt = 0; m_wcnt = 0; m_scnt = 0;
      end else begin
         st  = m_stall();
         pi  = (ph == 2) && ifm_read && !st;
         pw  = (ph == 2) && wgt_read && !st;
         shi = s_ifm_valid && mi.size() < 16;
         shw = s_wgt_valid && mw.size() < 16;
         if (pi) begin void'(mi.pop_front()); m_icnt++; end
         if (pw) begin void'(mw.pop_front()); m_wcnt++; end
         if (shi) mi.push_back(s_ifm_data);
         if (shw) mw.push_back(s_wgt_data);
         if (st) m_scnt++;
         case (ph)
            0: if (cmd_valid) begin
                  m_ci = cmd_ci; m_co = cmd_co;
                  m_icnt = 0; m_wcnt = 0; m_scnt = 0; ph = 1;
               end
            1: ph = 2;
            2: if (end_op) ph = 3;
            default: ph = 0;
         endcase
      end
   end

   // Monitor: every DUT output against the model, sampled mid-cycle.
   bit mst;
   always @(negedge clk) begin
      mst = m_stall();
      chk("stall", stall, mst);
      chk("ifm_head", ifm, (mi.size() != 0) ? mi[0] : 64'd0);
      chk("wgt_head", weight, (mw.size() != 0) ? {32'd0, mw[0]} : 64'd0);
      chk("s_ifm_ready", s_ifm_ready, mi.size() < 16);
      chk("s_wgt_ready", s_wgt_ready, mw.size() < 16);
      chk("cmd_ready", cmd_ready, ph == 0);
      chk("start_conv", start_conv, ph == 1);
      chk("busy", busy, ph != 0);
      chk("done", done, ph == 3);
      chk("cfg_ci", cfg_ci, m_ci);
      chk("cfg_co", cfg_co, m_co);
      chk("ifm_cnt", ifm_cnt, m_icnt);
      chk("wgt_cnt", wgt_cnt, m_wcnt);
      chk("stall_cnt", stall_cnt, m_scnt);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_ph(int p);
      int n = 0;
      while (ph != p && n < 50) begin step(); n++; end
      chk("phase_timeout", ph, p);
   endtask

   task automatic issue_cmd(logic [31:0] ci, logic [31:0] co);
      cmd_valid = 1; cmd_ci = ci; cmd_co = co;
      wait_ph(1);
      cmd_valid = 0;
      wait_ph(2);
   endtask

   task automatic finish_op();
      end_op = 1;
      wait_ph(3);
      end_op = 0;
      wait_ph(0);
   endtask

   logic [63:0] nxt;

   initial begin
      step(); step();
      rst = 0;
      step();
      // Prefetch in idle.
      for (int i = 1; i <= 4; i++) begin
         s_ifm_valid = 1; s_ifm_data = 64'(i);
         s_wgt_valid = 1; s_wgt_data = 32'(i + 16);
         step();
      end
      s_ifm_valid = 0; s_wgt_valid = 0;
      @(negedge clk);
      chk("prefetch_head", ifm, 64'h1);
      step();
      // Back-to-back reads with data buffered.
      issue_cmd(4, 8);
      chk("cfg_ci_4", cfg_ci, 4);
      chk("cfg_co_8", cfg_co, 8);
      ifm_read = 1; wgt_read = 1;
      repeat (4) step();
      ifm_read = 0; wgt_read = 0;
      @(negedge clk);
      chk("ifm_cnt_4", ifm_cnt, 4);
      chk("wgt_cnt_4", wgt_cnt, 4);
      chk("stall_cnt_0", stall_cnt, 0);
      step();
      finish_op();
      // Weight starvation for three cycles.
      for (int i = 0; i < 3; i++) begin
         s_ifm_valid = 1; s_ifm_data = 64'(32'hA0 + i); step();
      end
      s_ifm_valid = 0;
      issue_cmd(2, 3);
      ifm_read = 1; wgt_read = 1;
      step(); step();
      s_wgt_valid = 1; s_wgt_data = 32'hBEEF;
      step();
      s_wgt_valid = 0;
      step();
      ifm_read = 0; wgt_read = 0;
      @(negedge clk);
      chk("stall_cnt_3", stall_cnt, 3);
      chk("ifm_cnt_1", ifm_cnt, 1);
      chk("wgt_cnt_1", wgt_cnt, 1);
      step();
      finish_op();
      // Fill the IFM FIFO, then release one slot.
      nxt = 64'h100;
      s_ifm_valid = 1;
      for (int i = 0; i < 20; i++) begin
         s_ifm_data = nxt;
         if (mi.size() < 16) nxt++;
         step();
      end
      s_ifm_data = nxt;
      @(negedge clk);
      chk("full_ready_low", s_ifm_ready, 0);
      issue_cmd(1, 1);
      ifm_read = 1;
      step();
      ifm_read = 0;
      @(negedge clk);
      chk("ready_after_pop", s_ifm_ready, 1);
      step();
      s_ifm_valid = 0;
      ifm_read = 1;
      repeat (18) step();
      ifm_read = 0;
      finish_op();
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cmd_valid   = ($urandom % 4) == 0;
         cmd_ci      = $urandom; cmd_co = $urandom;
         s_ifm_valid = $urandom % 2;
         s_ifm_data  = {$urandom, $urandom};
         s_wgt_valid = $urandom % 2;
         s_wgt_data  = $urandom;
         ifm_read    = ($urandom % 3) != 0;
         wgt_read    = ($urandom % 3) != 0;
         end_op      = ($urandom % 16) == 0;
         step();
      end
      cmd_valid = 0; s_ifm_valid = 0; s_wgt_valid = 0;
      ifm_read = 0; wgt_read = 0; end_op = 1;
      wait_ph(0);
      end_op = 0;
      // Reset mid-run with words buffered and a weight-side stall pending.
      for (int i = 0; i < 5; i++) begin
         s_ifm_valid = 1; s_ifm_data = 64'(32'hC0 + i); step();
      end
      s_ifm_valid = 0;
      issue_cmd(7, 9);
      while (mw.size() != 0) begin wgt_read = 1; step(); end
      ifm_read = 1; wgt_read = 1;
      step();
      @(negedge clk); #2;
      rst = 1;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ifm", ifm, 0);
      chk("rst_ifm_cnt", ifm_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cfg_ci", cfg_ci, 0);
      ifm_read = 0; wgt_read = 0;
      step(); step();
      rst = 0;
      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
